// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// conv_window_gen : streaming KxK sliding-window generator (raster in, window out)
// Optional: define CONV_WIN_LAST_EN to build the win_last_o end-of-frame flag.
// Revision: 1.0
// ============================================================================
module conv_window_gen #(
  parameter int K     = 9,
  parameter int PIX_W = 16,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [PIX_W-1:0]              pix_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic [K*K-1:0][PIX_W-1:0]     win_o,
  output logic                          win_valid_o,
  input  logic                          win_ready_i
`ifdef CONV_WIN_LAST_EN
  ,
  output logic                          win_last_o
`endif
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] C_COL_MAX   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] C_ROW_MAX   = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] C_COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] C_ROW_FIRST = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] C_COL_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0] C_ROW_ONE   = ROW_W'(1);

  logic [COL_W-1:0]              r_col;
  logic [ROW_W-1:0]              r_row;
  logic                          r_win_valid;
  logic [K*K-1:0][PIX_W-1:0]     r_win;
  // Index 0 is the newest line (row-1), index K-2 the oldest (row-K+1).
  logic [PIX_W-1:0]              r_lb [K-1][IMG_W];
  logic [K-1:0][PIX_W-1:0]       w_col;
  logic                          w_accept;
  logic                          w_emit;
  logic                          w_col_end;
  logic                          w_row_end;

  assign pix_ready_o = !r_win_valid || win_ready_i;
  assign w_accept    = pix_valid_i && pix_ready_o && !clear_i;
  assign w_col_end   = (r_col == C_COL_MAX);
  assign w_row_end   = (r_row == C_ROW_MAX);
  assign w_emit      = (r_row >= C_ROW_FIRST) && (r_col >= C_COL_FIRST);

  assign win_o       = r_win;
  assign win_valid_o = r_win_valid;

  always_comb begin
    w_col = '0;
    for (int r = 0; r < K - 1; r++) begin
      w_col[r] = r_lb[K-2-r][r_col];
    end
    w_col[K-1] = pix_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else if (clear_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else if (w_accept) begin
      r_win_valid <= w_emit;
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + C_ROW_ONE;
      end else begin
        r_col <= r_col + C_COL_ONE;
      end
    end else if (win_ready_i) begin
      r_win_valid <= 1'b0;
    end
  end

  // Window only moves on accept, so it is frozen whenever pix_ready_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r*K+c] <= r_win[r*K+c+1];
        end
        r_win[r*K+K-1] <= w_col[r];
      end
    end
  end

  // Line buffers are deliberately unreset; no window is emitted before K rows refill them.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb[0][r_col] <= pix_i;
      for (int i = 1; i < K - 1; i++) begin
        r_lb[i][r_col] <= r_lb[i-1][r_col];
      end
    end
  end

`ifdef CONV_WIN_LAST_EN
  logic r_win_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win_last <= 1'b0;
    end else if (clear_i) begin
      r_win_last <= 1'b0;
    end else if (w_accept) begin
      r_win_last <= w_emit && w_col_end && w_row_end;
    end else if (win_ready_i) begin
      r_win_last <= 1'b0;
    end
  end

  assign win_last_o = r_win_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// tb_conv_window_gen : directed self-checking bench for conv_window_gen
// Revision: 1.0
// ============================================================================
module tb_conv_window_gen;

  localparam int K     = 9;
  localparam int PIX_W = 16;
  localparam int IMG_W = 16;
  localparam int IMG_H = 16;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      clear_i;
  logic [PIX_W-1:0]          pix_i;
  logic                      pix_valid_i;
  logic                      pix_ready_o;
  logic [K*K-1:0][PIX_W-1:0] win_o;
  logic                      win_valid_o;
  logic                      win_ready_i;
`ifdef CONV_WIN_LAST_EN
  logic                      win_last_o;
`endif

  int checks  = 0;
  int errors  = 0;
  int win_cnt = 0;
  int base;

  conv_window_gen #(.K(K), .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .win_o       (win_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i)
`ifdef CONV_WIN_LAST_EN
    ,
    .win_last_o  (win_last_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 0 if the window matches the one ending at (er,ec), else 1 + first bad index.
  function automatic int mism(input int er, input int ec);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (win_o[r*K+c] !== PIX_W'((er - K + 1 + r) * IMG_W + (ec - K + 1 + c)))
          return r * K + c + 1;
      end
    end
    return 0;
  endfunction

  task automatic run_frame(input int gap, input int stall_win, input int stop_r, input int stop_c);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (gap != 0 && $urandom_range(0, 1) == 1) begin
          pix_valid_i = 1'b0;
          @(posedge clk_i); #1;
          chk("gap_valid", win_valid_o, 0);
        end
        pix_i       = PIX_W'(r * IMG_W + c);
        pix_valid_i = 1'b1;
        @(posedge clk_i); #1;
        pix_valid_i = 1'b0;
        chk("win_valid", win_valid_o, (r >= K - 1 && c >= K - 1));
        if (r >= K - 1 && c >= K - 1) begin
          win_cnt++;
          chk("window", mism(r, c), 0);
`ifdef CONV_WIN_LAST_EN
          chk("win_last", win_last_o, (r == IMG_H - 1 && c == IMG_W - 1));
`endif
          if (win_cnt == stall_win) begin
            win_ready_i = 1'b0;
            pix_i       = 16'hDEAD;
            pix_valid_i = 1'b1;
            repeat (5) begin
              @(posedge clk_i); #1;
              chk("stall_pix_ready", pix_ready_o, 0);
              chk("stall_valid", win_valid_o, 1);
              chk("stall_window", mism(r, c), 0);
            end
            pix_valid_i = 1'b0;
            win_ready_i = 1'b1;
          end
        end
        if (r == stop_r && c == stop_c) return;
      end
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    pix_i       = '0;
    pix_valid_i = 1'b0;
    win_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", win_valid_o, 0);
    chk("rst_pix_ready", pix_ready_o, 1);
    chk("rst_win_zero", (win_o === '0), 1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Frame 1: continuous stream
    run_frame(0, 0, -1, -1);
    chk("frame1_count", win_cnt, 64);
    chk("last_win0", win_o[0], 119);
    chk("last_win80", win_o[80], 255);

    // Frame 2 back-to-back, backpressure on its 3rd window
    run_frame(0, win_cnt + 3, -1, -1);
    chk("frame2_count", win_cnt, 128);

    // Frame 3 with random input gaps
    run_frame(1, 0, -1, -1);
    chk("frame3_count", win_cnt, 192);

    // Asynchronous reset in the middle of row 10 while a window is valid
    run_frame(0, 0, 10, 10);
    chk("pre_reset_valid", win_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", win_valid_o, 0);
    chk("async_rst_win_zero", (win_o === '0), 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    base = win_cnt;
    run_frame(0, 0, -1, -1);
    chk("post_reset_count", win_cnt - base, 64);

    // Clear together with an accept at (12,5)
    run_frame(0, 0, 12, 4);
    pix_i       = PIX_W'(12 * IMG_W + 5);
    pix_valid_i = 1'b1;
    clear_i     = 1'b1;
    #1;
    chk("clear_pix_ready", pix_ready_o, 1);
    @(posedge clk_i); #1;
    clear_i     = 1'b0;
    pix_valid_i = 1'b0;
    chk("clear_valid", win_valid_o, 0);
    base = win_cnt;
    run_frame(0, 0, -1, -1);
    chk("post_clear_count", win_cnt - base, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
